alu_core: RTL and testbench

- 32-bit single-cycle-compute, registered-output arithmetic/logic unit for the processor datapath.
- Selects one of 19 operations on operands a and b via a 5-bit opcode.
- Captures the result into the out register on the rising clock edge when enable is high.
- Sits between the register-file read ports and the writeback/forwarding logic.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_if.sv | 26 ++
 rtl/alu_shifter.sv | 41 ++++
 rtl/alu_core.sv | 82 ++++++++
 tb/tb_alu_core.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and helper types for the ALU and its decoder.
package alu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD   = 5'b00000;
    localparam opcode_t OP_INC   = 5'b00001;
    localparam opcode_t OP_SUB   = 5'b00010;
    localparam opcode_t OP_MUL   = 5'b00011;
    localparam opcode_t OP_DEC   = 5'b00100;
    localparam opcode_t OP_NEG   = 5'b00101;
    localparam opcode_t OP_SLT   = 5'b00110;
    localparam opcode_t OP_SLTU  = 5'b00111;
    localparam opcode_t OP_SLL   = 5'b01000;
    localparam opcode_t OP_SRL   = 5'b01001;
    localparam opcode_t OP_SRA   = 5'b01010;
    localparam opcode_t OP_AND   = 5'b01011;
    localparam opcode_t OP_OR    = 5'b01100;
    localparam opcode_t OP_XOR   = 5'b01101;
    localparam opcode_t OP_NOR   = 5'b01110;
    localparam opcode_t OP_XNOR  = 5'b01111;
    localparam opcode_t OP_NOT   = 5'b10000;
    localparam opcode_t OP_PASSA = 5'b10001;
    localparam opcode_t OP_PASSB = 5'b10010;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_mode_t;

    function automatic logic is_shift(input opcode_t op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode bus between the register-file read side and the ALU.
interface alu_if #(
    parameter int WIDTH = 32
);
    alu_pkg::opcode_t   opcode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               enable;
    logic [WIDTH-1:0]   out;

    modport master (
        output opcode,
        output a,
        output b,
        output enable,
        input  out
    );

    modport slave (
        input  opcode,
        input  a,
        input  b,
        input  enable,
        output out
    );
endinterface

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter for SLL/SRL/SRA; left shifts reuse the right-shift
// stages by bit-reversing the operand on the way in and out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  shift_mode_t      mode,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] y
);

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    logic             fill;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        src     = (mode == SH_LL) ? bit_reverse(a) : a;
        fill    = (mode == SH_RA) && a[WIDTH-1];
        shifted = src;
        // Each stage shifts by a power of two and back-fills with the sign for SRA.
        for (int k = 0; k < SHW; k++) begin
            if (shamt[k]) begin
                shifted = (shifted >> (1 << k))
                        | (fill ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
            end
        end
        y = (mode == SH_LL) ? bit_reverse(shifted) : shifted;
    end

endmodule

// File: rtl/alu_core.sv
// Registered-output 32-bit ALU: combinational compute from opcode/a/b,
// captured into out on enabled rising edges.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    lt_s;
    logic                    lt_u;
    shift_mode_t             sh_mode;
    logic [WIDTH-1:0]        sh_y;
    logic [WIDTH-1:0]        result_p0;

    assign a_s  = bus.a;
    assign b_s  = bus.b;
    assign lt_s = a_s < b_s;
    assign lt_u = bus.a < bus.b;

    always_comb begin
        sh_mode = SH_LL;
        case (bus.opcode)
            OP_SRL:  sh_mode = SH_RL;
            OP_SRA:  sh_mode = SH_RA;
            default: sh_mode = SH_LL;
        endcase
    end

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .mode  (sh_mode),
        .a     (bus.a),
        .shamt (bus.b[SHW-1:0]),
        .y     (sh_y)
    );

    // Stage p0: combinational result; all arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        result_p0 = '0;
        case (bus.opcode)
            OP_ADD:   result_p0 = bus.a + bus.b;
            OP_INC:   result_p0 = bus.a + WIDTH'(1);
            OP_SUB:   result_p0 = bus.a - bus.b;
            OP_MUL:   result_p0 = bus.a * bus.b;
            OP_DEC:   result_p0 = bus.a - WIDTH'(1);
            OP_NEG:   result_p0 = '0 - bus.a;
            OP_SLT:   result_p0 = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:  result_p0 = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLL,
            OP_SRL,
            OP_SRA:   result_p0 = sh_y;
            OP_AND:   result_p0 = bus.a & bus.b;
            OP_OR:    result_p0 = bus.a | bus.b;
            OP_XOR:   result_p0 = bus.a ^ bus.b;
            OP_NOR:   result_p0 = ~(bus.a | bus.b);
            OP_XNOR:  result_p0 = ~(bus.a ^ bus.b);
            OP_NOT:   result_p0 = ~bus.a;
            OP_PASSA: result_p0 = bus.a;
            OP_PASSB: result_p0 = bus.b;
            default:  result_p0 = '0;
        endcase
    end

    // Stage p1: output register; reset clears it asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out <= '0;
        end else if (bus.enable) begin
            bus.out <= result_p0;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed spec vectors plus randomized ops
// against a plain-arithmetic reference model.
module tb_alu_core;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    alu_if #(.WIDTH(32)) bus ();

    alu_core #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_out = '0;

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        int              sa = a;
        int              sb = b;
        int unsigned     sh = b & 32'd31;
        case (op)
            5'd0:  return 32'(ua + ub);
            5'd1:  return 32'(ua + 64'd1);
            5'd2:  return 32'(ua - ub);
            5'd3:  return 32'(ua * ub);
            5'd4:  return 32'(ua - 64'd1);
            5'd5:  return 32'(64'd0 - ua);
            5'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return 32'(ua << sh);
            5'd9:  return a >> sh;
            5'd10: return a[31] ? ~((~a) >> sh) : (a >> sh);
            5'd11: return a & b;
            5'd12: return a | b;
            5'd13: return a ^ b;
            5'd14: return ~(a | b);
            5'd15: return ~(a ^ b);
            5'd16: return ~a;
            5'd17: return a;
            5'd18: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic en);
        @(negedge clk);
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        bus.enable = en;
        @(posedge clk);
        #1;
        if (en) exp_out = model(op, a, b);
    endtask

    task automatic test_reset();
        bus.opcode = OP_ADD; bus.a = '0; bus.b = '0; bus.enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== 32'd0) begin
            errors++; $display("FAIL reset_init out=%h expected=%h", bus.out, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_out = '0;
        apply(OP_ADD, 32'h0000_00A5, 32'h0000_0010, 1'b1);
        checks++;
        if (bus.out !== 32'h0000_00B5) begin
            errors++; $display("FAIL reset_precapture out=%h expected=%h", bus.out, 32'h0000_00B5);
        end
        // Pending enabled capture, then reset mid-cycle with no clock edge in between.
        @(negedge clk);
        bus.a = 32'h1234_5678; bus.enable = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== 32'd0) begin
            errors++; $display("FAIL reset_async out=%h expected=%h", bus.out, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.enable = 1'b0; bus.opcode = OP_ADD; bus.a = 32'd5; bus.b = 32'd3;
        exp_out = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out !== 32'd0) begin
                errors++; $display("FAIL reset_hold[%0d] out=%h expected=%h", i, bus.out, 32'd0);
            end
        end
    endtask

    task automatic test_arith();
        logic [4:0]  ops [5] = '{OP_ADD, OP_SUB, OP_SUB, OP_MUL, OP_MUL};
        logic [31:0] as  [5] = '{32'h0F0F0F0F, 32'd4528, 32'd0, 32'd45562, 32'hFFFFFFFF};
        logic [31:0] bs  [5] = '{32'd0, 32'd4500, 32'd1, 32'd45500, 32'd2};
        logic [31:0] ex  [5] = '{32'h0F0F0F0F, 32'd28, 32'hFFFFFFFF, 32'd2073071000, 32'hFFFFFFFE};
        for (int i = 0; i < 5; i++) begin
            apply(ops[i], as[i], bs[i], 1'b1);
            checks++;
            if (bus.out !== ex[i]) begin
                errors++; $display("FAIL arith[%0d] op=%0d out=%h expected=%h", i, ops[i], bus.out, ex[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [4:0]  ops [4] = '{OP_XOR, OP_NOR, OP_XNOR, OP_AND};
        logic [31:0] ex  [4] = '{32'hF0F0F0F0, 32'h00000000, 32'h0F0F0F0F, 32'h0F0F0F0F};
        for (int i = 0; i < 4; i++) begin
            apply(ops[i], 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b1);
            checks++;
            if (bus.out !== ex[i]) begin
                errors++; $display("FAIL logic[%0d] op=%0d out=%h expected=%h", i, ops[i], bus.out, ex[i]);
            end
        end
    endtask

    task automatic test_shift_cmp();
        logic [4:0]  ops [7] = '{OP_SRA, OP_SRL, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};
        logic [31:0] as  [7] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h80001234, 32'h80001234, 32'h80001234};
        logic [31:0] bs  [7] = '{32'd4, 32'd4, 32'd1, 32'd1, 32'hFFFFFFE0, 32'hFFFFFFE0, 32'hFFFFFFE0};
        logic [31:0] ex  [7] = '{32'hF8000000, 32'h08000000, 32'd1, 32'd0,
                                 32'h80001234, 32'h80001234, 32'h80001234};
        for (int i = 0; i < 7; i++) begin
            apply(ops[i], as[i], bs[i], 1'b1);
            checks++;
            if (bus.out !== ex[i]) begin
                errors++; $display("FAIL shift_cmp[%0d] op=%0d out=%h expected=%h", i, ops[i], bus.out, ex[i]);
            end
        end
    endtask

    task automatic test_enable_reserved();
        apply(OP_ADD, 32'd1, 32'd1, 1'b1);
        checks++;
        if (bus.out !== 32'd2) begin
            errors++; $display("FAIL en_capture out=%h expected=%h", bus.out, 32'd2);
        end
        for (int i = 0; i < 2; i++) begin
            apply(OP_SUB, 32'd9, 32'd4, 1'b0);
            checks++;
            if (bus.out !== 32'd2) begin
                errors++; $display("FAIL en_hold[%0d] out=%h expected=%h", i, bus.out, 32'd2);
            end
        end
        for (int op = 31; op >= 19; op--) begin
            apply(5'(op), $urandom | 32'h1, $urandom, 1'b1);
            checks++;
            if (bus.out !== 32'd0) begin
                errors++; $display("FAIL reserved op=%0d out=%h expected=%h", op, bus.out, 32'd0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000001F};
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        logic        ren;
        for (int i = 0; i < 400; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            ren = ($urandom_range(0, 3) != 0);
            apply(rop, ra, rb, ren);
            checks++;
            if (bus.out !== exp_out) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h en=%0b out=%h expected=%h",
                         i, rop, ra, rb, ren, bus.out, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift_cmp();
        test_enable_reserved();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
